// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one writeback port,
// same-cycle write bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [AW-1:0]         rs1,
    input  logic [AW-1:0]         rs2,
    output logic [XLEN-1:0]       out1,
    output logic [XLEN-1:0]       out2,
    output logic                  rdy1,
    output logic                  rdy2,
    input  logic                  rw,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       din,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ok,
    output logic [(2**AW)-1:0]    busy_vec
);

    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    logic            zero1;
    logic            zero2;
    logic            byp1;
    logic            byp2;
    logic            wr_en;
    logic            iss_zero;
    logic            iss_set;
    logic [XLEN-1:0] nxt_out1;
    logic [XLEN-1:0] nxt_out2;
    logic            nxt_rdy1;
    logic            nxt_rdy2;

    always_comb begin
        zero1    = ZERO_REG && (rs1 == '0);
        zero2    = ZERO_REG && (rs2 == '0);
        byp1     = rw && (rd == rs1) && !zero1;
        byp2     = rw && (rd == rs2) && !zero2;
        wr_en    = rw && !(ZERO_REG && (rd == '0));
        iss_zero = ZERO_REG && (iss_rd == '0);
        iss_ok   = !busy[iss_rd] || (rw && (rd == iss_rd)) || iss_zero;
        iss_set  = enable && iss_valid && iss_ok && !iss_zero;
    end

    always_comb begin
        nxt_out1 = mem[rs1];
        nxt_rdy1 = !busy[rs1];
        if (zero1) begin
            nxt_out1 = '0;
            nxt_rdy1 = 1'b1;
        end else if (byp1) begin
            nxt_out1 = din;
            nxt_rdy1 = 1'b1;
        end
    end

    always_comb begin
        nxt_out2 = mem[rs2];
        nxt_rdy2 = !busy[rs2];
        if (zero2) begin
            nxt_out2 = '0;
            nxt_rdy2 = 1'b1;
        end else if (byp2) begin
            nxt_out2 = din;
            nxt_rdy2 = 1'b1;
        end
    end

    // Issue set is applied after the writeback clear so it wins on a tie.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[rd] = 1'b0;
        end
        if (iss_set) begin
            busy_nxt[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
            out1 <= '0;
            out2 <= '0;
            rdy1 <= 1'b1;
            rdy2 <= 1'b1;
        end else begin
            if (wr_en) begin
                mem[rd] <= din;
            end
            busy <= busy_nxt;
            if (enable) begin
                out1 <= nxt_out1;
                out2 <= nxt_out2;
                rdy1 <= nxt_rdy1;
                rdy2 <= nxt_rdy2;
            end
        end
    end

    assign busy_vec = busy;

endmodule
